// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture block: segment patterns,
// the invalid-digit code and the frame acquisition state type.
package seg7_pkg;
    localparam logic [6:0] SEG_D0    = 7'b0111111;
    localparam logic [6:0] SEG_D1    = 7'b0000110;
    localparam logic [6:0] SEG_D2    = 7'b1011011;
    localparam logic [6:0] SEG_D3    = 7'b1001111;
    localparam logic [6:0] SEG_D4    = 7'b1100110;
    localparam logic [6:0] SEG_D5    = 7'b1101101;
    localparam logic [6:0] SEG_D6    = 7'b1111101;
    localparam logic [6:0] SEG_D7    = 7'b0000111;
    localparam logic [6:0] SEG_D8    = 7'b1111111;
    localparam logic [6:0] SEG_D9    = 7'b1100111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic {SYNC = 1'b0, ACQ = 1'b1} cap_state_e;
endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern to BCD lookup.
// SEG7_CAP_ERR_EN: unknown patterns decode to BCD_INVALID and raise invalid_o.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] bcd_o,
    output logic       blank_o,
    output logic       invalid_o
);
    always_comb begin
        bcd_o     = 4'd0;
        blank_o   = 1'b0;
        invalid_o = 1'b0;
        case (seg_i)
            SEG_D0:    bcd_o = 4'd0;
            SEG_D1:    bcd_o = 4'd1;
            SEG_D2:    bcd_o = 4'd2;
            SEG_D3:    bcd_o = 4'd3;
            SEG_D4:    bcd_o = 4'd4;
            SEG_D5:    bcd_o = 4'd5;
            SEG_D6:    bcd_o = 4'd6;
            SEG_D7:    bcd_o = 4'd7;
            SEG_D8:    bcd_o = 4'd8;
            SEG_D9:    bcd_o = 4'd9;
            SEG_BLANK: blank_o = 1'b1;
            default: begin
`ifdef SEG7_CAP_ERR_EN
                bcd_o     = BCD_INVALID;
                invalid_o = 1'b1;
`endif
            end
        endcase
    end
endmodule

// File: rtl/seg7_bcd_capture.sv
// Captures a multiplexed seven-segment display into BCD frames with a
// valid/ready output. SEG7_CAP_ERR_EN enables the sticky invalid-pattern flag.
module seg7_bcd_capture
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [6:0]        seg_i,
    input  logic [NDIG-1:0]   dig_en_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [4*NDIG-1:0] bcd_o,
    output logic [NDIG-1:0]   blank_o,
    output logic              err_o,
    output logic              ovf_o
);
    localparam int CW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam int IW = $clog2(NDIG);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

    logic [6:0]        seg_q, seg_prev_q;
    logic [NDIG-1:0]   dig_q, dig_prev_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              capt_q, capt_d;
    cap_state_e        state_q, state_d;
    logic [NDIG-1:0]   mask_q, mask_d;
    logic [4*NDIG-1:0] fbcd_q, fbcd_d, fbcd_n;
    logic [NDIG-1:0]   fblk_q, fblk_d, fblk_n;
    logic              ov_q, ov_d, ovf_q, ovf_d;
    logic [4*NDIG-1:0] obcd_q, obcd_d;
    logic [NDIG-1:0]   oblk_q, oblk_d;
    logic [IW-1:0]     idx;
    logic [3:0]        dec_bcd;
    logic              dec_blk, dec_inv;
    logic              same, cap, done;

    seg7_to_bcd u_dec (
        .seg_i     (seg_q),
        .bcd_o     (dec_bcd),
        .blank_o   (dec_blk),
        .invalid_o (dec_inv)
    );

    // Stability tracking works purely on the registered samples.
    assign same  = (seg_q == seg_prev_q) && (dig_q == dig_prev_q) && $onehot(dig_q);
    assign cnt_d = !same ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    assign cap   = same && !capt_q && (cnt_d == CNT_MAX);
    assign capt_d = same && (capt_q || cap);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NDIG; i++)
            if (dig_q[i]) idx = IW'(i);
    end

    always_comb begin
        fbcd_n = fbcd_q;
        fblk_n = fblk_q;
        fbcd_n[4*idx +: 4] = dec_bcd;
        fblk_n[idx]        = dec_blk;
        state_d = state_q;
        mask_d  = mask_q;
        fbcd_d  = fbcd_q;
        fblk_d  = fblk_q;
        done    = 1'b0;
        if (cap) begin
            if (state_q == ACQ && !mask_q[idx]) begin
                fbcd_d = fbcd_n;
                fblk_d = fblk_n;
                if ((mask_q | dig_q) == '1) begin
                    done    = 1'b1;
                    mask_d  = '0;
                    state_d = SYNC;
                end else begin
                    mask_d = mask_q | dig_q;
                end
            end else if (idx == '0) begin
                // repeated digit 0 while acquiring restarts the frame here
                fbcd_d  = fbcd_n;
                fblk_d  = fblk_n;
                mask_d  = NDIG'(1);
                state_d = ACQ;
            end else begin
                mask_d  = '0;
                state_d = SYNC;
            end
        end
    end

    always_comb begin
        ov_d   = ov_q;
        obcd_d = obcd_q;
        oblk_d = oblk_q;
        ovf_d  = ovf_q;
        if (done) begin
            if (!ov_q || out_ready_i) begin
                ov_d   = 1'b1;
                obcd_d = fbcd_n;
                oblk_d = fblk_n;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (ov_q && out_ready_i) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            seg_q      <= '0;
            seg_prev_q <= '0;
            dig_q      <= '0;
            dig_prev_q <= '0;
            cnt_q      <= '0;
            capt_q     <= 1'b0;
            state_q    <= SYNC;
            mask_q     <= '0;
            fbcd_q     <= '0;
            fblk_q     <= '0;
            ov_q       <= 1'b0;
            obcd_q     <= '0;
            oblk_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            seg_q      <= seg_i;
            seg_prev_q <= seg_q;
            dig_q      <= dig_en_i;
            dig_prev_q <= dig_q;
            cnt_q      <= cnt_d;
            capt_q     <= capt_d;
            state_q    <= state_d;
            mask_q     <= mask_d;
            fbcd_q     <= fbcd_d;
            fblk_q     <= fblk_d;
            ov_q       <= ov_d;
            obcd_q     <= obcd_d;
            oblk_q     <= oblk_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef SEG7_CAP_ERR_EN
    logic err_q, err_d;
    assign err_d = err_q || (cap && dec_inv);
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) err_q <= 1'b0;
        else          err_q <= err_d;
    end
    assign err_o = err_q;
`else
    logic unused_inv;
    assign unused_inv = dec_inv;
    assign err_o      = 1'b0;
`endif

    assign out_valid_o = ov_q;
    assign bcd_o       = obcd_q;
    assign blank_o     = oblk_q;
    assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_seg7_bcd_capture.sv
// Bench for seg7_bcd_capture: directed frame table, hand sequences and random
// scans, all checked every cycle against a run-length reference model.
module tb_seg7_bcd_capture;
    localparam int NDIG = 4;
    localparam int SC   = 4;
`ifdef SEG7_CAP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [6:0] P0 = 7'b0111111, P1 = 7'b0000110, P2 = 7'b1011011,
                           P3 = 7'b1001111, P4 = 7'b1100110, P5 = 7'b1101101,
                           P6 = 7'b1111101, P7 = 7'b0000111, P8 = 7'b1111111,
                           P9 = 7'b1100111, PB = 7'b0000000, PX = 7'b1010101;

    logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b0;
    logic [6:0] seg = '0;
    logic [NDIG-1:0] dig = '0;
    logic ov, err, ovf;
    logic [4*NDIG-1:0] bcd;
    logic [NDIG-1:0] blk;
    int nvec = 0, nerr = 0;

    seg7_bcd_capture #(.NDIG(NDIG), .STABLE_CYC(SC)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .seg_i(seg), .dig_en_i(dig),
        .out_ready_i(rdy), .out_valid_o(ov), .bcd_o(bcd), .blank_o(blk),
        .err_o(err), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] pat_tbl [0:9] = '{P0, P1, P2, P3, P4, P5, P6, P7, P8, P9};
    int         run_len;
    logic [6:0] run_seg;
    logic [NDIG-1:0] run_dig;
    bit         pend, acq;
    logic [6:0] pend_seg;
    int         pend_idx;
    bit         have [NDIG];
    logic [3:0] slot_bcd [NDIG];
    bit         slot_blk [NDIG];
    logic       m_v, m_err, m_ovf;
    logic [4*NDIG-1:0] m_bcd;
    logic [NDIG-1:0]   m_blk;

    function automatic void decode(input logic [6:0] s, output logic [3:0] b,
                                   output bit bl, output bit inv);
        b = 4'd0; bl = (s == 7'd0); inv = !bl;
        for (int k = 0; k < 10; k++)
            if (s == pat_tbl[k]) begin b = k[3:0]; inv = 1'b0; end
        if (inv && ERR_EN) b = 4'hF;
    endfunction

    always @(posedge clk) begin : model
        logic [3:0] b;
        bit bl, inv, done, all;
        if (!rst_n) begin
            run_len = 0; pend = 0; acq = 0;
            m_v = 0; m_err = 0; m_ovf = 0; m_bcd = '0; m_blk = '0;
            for (int i = 0; i < NDIG; i++) begin
                have[i] = 0; slot_bcd[i] = '0; slot_blk[i] = 0;
            end
        end else begin
            done = 0;
            if (pend) begin
                decode(pend_seg, b, bl, inv);
                if (inv && ERR_EN) m_err = 1;
                if (acq && !have[pend_idx]) begin
                    have[pend_idx] = 1; slot_bcd[pend_idx] = b; slot_blk[pend_idx] = bl;
                    all = 1;
                    for (int i = 0; i < NDIG; i++) all = all && have[i];
                    if (all) begin
                        done = 1; acq = 0;
                        for (int i = 0; i < NDIG; i++) have[i] = 0;
                    end
                end else begin
                    for (int i = 0; i < NDIG; i++) have[i] = 0;
                    acq = 0;
                    if (pend_idx == 0) begin
                        have[0] = 1; acq = 1; slot_bcd[0] = b; slot_blk[0] = bl;
                    end
                end
            end
            if (done) begin
                if (!m_v || rdy) begin
                    m_v = 1;
                    for (int i = 0; i < NDIG; i++) begin
                        m_bcd[4*i +: 4] = slot_bcd[i];
                        m_blk[i] = slot_blk[i];
                    end
                end else m_ovf = 1;
            end else if (m_v && rdy) m_v = 0;
            // a capture is due once the same one-hot sample has been seen SC times
            if ($onehot(dig)) begin
                if (run_len > 0 && seg == run_seg && dig == run_dig) run_len++;
                else begin run_len = 1; run_seg = seg; run_dig = dig; end
            end else run_len = 0;
            pend     = (run_len == SC);
            pend_seg = seg;
            pend_idx = $clog2(dig);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [22:0] got, input logic [22:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    function automatic logic [22:0] dut_pack();
        return {ov, bcd, blk, err, ovf};
    endfunction

    task automatic drive(input logic [6:0] s, input logic [NDIG-1:0] d, input int n);
        for (int c = 0; c < n; c++) begin
            seg = s; dig = d;
            @(negedge clk);
            chk("model", dut_pack(), {m_v, m_bcd, m_blk, m_err, m_ovf});
        end
    endtask

    task automatic scan4(input logic [6:0] s0, s1, s2, s3, input int dw2);
        drive(s0, 4'b0001, 6);
        drive(s1, 4'b0010, 6);
        drive(s2, 4'b0100, dw2);
        drive(s3, 4'b1000, 6);
        drive(7'd0, 4'b0000, 3);
    endtask

    task automatic ack();
        rdy = 1'b1;
        drive(7'd0, 4'b0000, 1);
        rdy = 1'b0;
        chk("ack_valid_fall", {22'd0, ov}, 23'd0);
    endtask

    typedef struct packed {
        logic [3:0][6:0] s;
        logic [7:0]      dw2;
        logic            do_ack;
        logic [22:0]     exp;
    } vec_t;

    function automatic vec_t mk(input logic [6:0] s0, s1, s2, s3, input int dw2,
                                input logic a, input logic [22:0] e);
        vec_t v;
        v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
        v.dw2 = dw2[7:0]; v.do_ack = a; v.exp = e;
        return v;
    endfunction

    vec_t tbl [6];

    initial begin
        // expected fields: {valid, bcd, blank, err, ovf}
        tbl[0] = mk(P1, P2, P3, P4, 6, 1, {1'b1, 16'h4321, 4'b0000, 1'b0, 1'b0});
        tbl[1] = mk(P5, P6, P7, P8, 3, 0, {1'b0, 16'h4321, 4'b0000, 1'b0, 1'b0});
        tbl[2] = mk(P9, P0, P1, P2, 6, 0, {1'b1, 16'h2109, 4'b0000, 1'b0, 1'b0});
        tbl[3] = mk(P3, P4, P5, P6, 6, 1, {1'b1, 16'h2109, 4'b0000, 1'b0, 1'b1});
        tbl[4] = mk(P7, PB, P8, P9, 6, 1, {1'b1, 16'h9807, 4'b0010, 1'b0, 1'b1});
        tbl[5] = mk(P1, P2, P3, PX, 6, 1,
                    {1'b1, (ERR_EN ? 16'hF321 : 16'h0321), 4'b0000, ERR_EN, 1'b1});

        rst_n = 1'b0;
        drive(7'd0, 4'b0000, 3);
        chk("reset_state", dut_pack(), 23'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            scan4(tbl[i].s[0], tbl[i].s[1], tbl[i].s[2], tbl[i].s[3], int'(tbl[i].dw2));
            chk($sformatf("table%0d", i), dut_pack(), tbl[i].exp);
            if (tbl[i].do_ack) ack();
        end

        // reset mid-frame, then resume from digit 2
        drive(P1, 4'b0001, 6);
        drive(P2, 4'b0010, 6);
        rst_n = 1'b0;
        drive(7'd0, 4'b0000, 2);
        chk("reset_midframe", dut_pack(), 23'd0);
        rst_n = 1'b1;
        drive(P3, 4'b0100, 6);
        drive(P4, 4'b1000, 6);
        drive(7'd0, 4'b0000, 3);
        chk("resume_no_frame", dut_pack(), 23'd0);
        scan4(P5, P6, P7, P8, 6);
        chk("resume_frame", dut_pack(), {1'b1, 16'h8765, 4'b0000, 1'b0, 1'b0});
        ack();

        // multi-hot strobe must not stand in for digit 0
        drive(P1, 4'b0011, 10);
        drive(P2, 4'b0010, 6);
        drive(P3, 4'b0100, 6);
        drive(P4, 4'b1000, 6);
        drive(7'd0, 4'b0000, 3);
        chk("multihot_no_frame", dut_pack(), {1'b0, 16'h8765, 4'b0000, 1'b0, 1'b0});

        // randomized scans with random consumer back-pressure
        begin
            int d, dw, r;
            logic [6:0] s;
            logic [NDIG-1:0] de;
            d = 0;
            for (int n = 0; n < 300; n++) begin
                r  = $urandom_range(0, 11);
                s  = (r < 10) ? pat_tbl[r] : (r == 10) ? PB : PX;
                de = 4'b0001 << d;
                if ($urandom_range(0, 9) == 0) de = 4'($urandom_range(0, 15));
                dw = $urandom_range(2, 7);
                for (int c = 0; c < dw; c++) begin
                    rdy = ($urandom_range(0, 2) == 0);
                    drive(s, de, 1);
                end
                d = (d + 1) % NDIG;
            end
            rdy = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/seg7_bcd_capture.md
SEG7_BCD_CAPTURE -- requirements
Module: seg7_bcd_capture

Interface
REQ-001 Parameter NDIG, default 4, number of multiplexed digits (2..8).
REQ-002 Parameter STABLE_CYC, default 4, consecutive identical samples required before capture (2..255).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 seg  input  7  segment bus, active-high, bit0=a .. bit6=g.
REQ-006 dig_en  input  NDIG  digit strobe, one-hot when valid; bit i selects digit i.
REQ-007 out_ready  input  1  consumer accepts frame when high with out_valid.
REQ-008 out_valid  output  1  completed frame available.
REQ-009 bcd  output  4*NDIG  decoded frame, digit i at bits [4i+3:4i].
REQ-010 blank  output  NDIG  digit i was all-segments-off.
REQ-011 err  output  1  sticky: invalid pattern captured.
REQ-012 ovf  output  1  sticky: frame dropped because out_valid held unaccepted.

Function
REQ-013 Decode table (seg -> bcd) SHALL be: 0111111->0, 0000110->1, 1011011->2, 1001111->3, 1100110->4, 1101101->5, 1111101->6, 0000111->7, 1111111->8, 1100111->9; 0000000 -> bcd 0 with blank=1; all other patterns invalid.
REQ-014 seg and dig_en SHALL be registered once on entry; all further logic uses registered samples.
REQ-015 Stability counter SHALL increment each cycle the registered sample equals the previous registered sample and dig_en is one-hot, else reset to 0; saturates at STABLE_CYC-1.
REQ-016 Zero or multi-hot dig_en SHALL clear the counter and prevent capture.
REQ-017 Capture SHALL occur on the edge where the counter reaches STABLE_CYC-1: slot i (per dig_en) written with decoded value and blank bit; capture-mask bit i set.
REQ-018 A captured flag SHALL block recapture until the sample changes; one capture per strobe dwell.
REQ-019 State machine SYNC/ACQ: SYNC discards captures except digit 0; a digit-0 capture enters ACQ with mask=0...01.
REQ-020 In ACQ, capture of a digit whose mask bit is already set SHALL clear the mask and return to SYNC (that capture re-evaluated as in SYNC).
REQ-021 When the mask becomes all-ones, the frame SHALL transfer to the output register and out_valid SHALL rise the next cycle; mask clears, state returns to SYNC.
REQ-022 out_valid, bcd, blank SHALL hold stable while out_valid=1 and out_ready=0; handshake completes on edge with both high, out_valid falls next cycle unless a new frame loads that same edge.
REQ-023 Frame completing while out_valid=1 and out_ready=0 SHALL be dropped, output unchanged, ovf set.
REQ-024 Frame completing on the same edge as an accepting handshake SHALL load, out_valid stays 1.
REQ-025 err and ovf SHALL clear only on reset.

Reset
REQ-026 rst_n=0 at a rising edge SHALL set out_valid=0, bcd=0, blank=0, err=0, ovf=0, mask=0, counter=0, captured=0, state=SYNC, input registers=0.
REQ-027 Reset mid-frame SHALL discard partial frames; first capture after release requires full STABLE_CYC dwell.

Configuration
REQ-028 Macro SEG7_CAP_ERR_EN defined: invalid patterns captured as bcd 4'hF, blank=0, err set.
REQ-029 Macro undefined: invalid patterns captured as bcd 0, blank=0; err tied 0; no detection logic.

Structure
REQ-030 Package seg7_pkg SHALL hold the ten segment pattern constants, SEG_BLANK, BCD_INVALID (4'hF), and the SYNC/ACQ state type.
REQ-031 Sub-module seg7_to_bcd SHALL be the combinational pattern lookup (seg in; bcd, blank, invalid out), instantiated once.

Verification
REQ-032 NDIG=4, STABLE_CYC=4; scan digits 0..3 showing 1,2,3,4 each 6 cycles -> out_valid, bcd=16'h4321, blank=0.
REQ-033 Digit 2 dwell only 3 cycles -> no frame that scan; next full scan yields frame.
REQ-034 Two frames with out_ready=0 -> first frame held, ovf=1; out_ready=1 -> first frame accepted, out_valid falls.
REQ-035 Digit 1 shows 0000000 -> bcd nibble 1 = 0, blank=4'b0010.
REQ-036 Digit 3 shows 1010101 with SEG7_CAP_ERR_EN -> nibble 3 = F, err=1; without macro -> nibble 3 = 0, err=0.
REQ-037 rst_n low after digits 0,1 captured -> all outputs 0, state SYNC; resumed scan from digit 2 produces no frame until digit 0 recaptured.
